serial_adder: RTL and testbench

Bit-serial ripple adder that reuses a single `full_adder` cell across `WIDTH` clock cycles, consuming operands LSB-first and producing a registered `WIDTH`-bit sum with carry-out and signed overflow. It is the sequential, area-minimal counterpart of the combinational adder path in the datapath lab. It accepts operands through a start/done handshake and holds the result until the next operation. With the subtract feature compiled in, it also serves as the ALU's serial subtractor.

---
 rtl/serial_adder.sv | 124 ++++++++++++
 tb/tb_serial_adder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles, operands LSB-first.
// Define SERIAL_ADDER_SUB_EN to add the sub port (A - B via ~B and carry-in 1).

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// state | meaning
// IDLE  | waiting for start, result held
// RUN   | one bit per cycle through the full adder
// FIN   | result valid, done pulse; start here chains the next operation
module serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_co;
  logic             sub_sel;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic [WIDTH-1:0] res_next;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign b_load   = sub_sel ? ~B : B;
  assign c_load   = sub_sel ? 1'b1 : Cin;
  assign res_next = {fa_s, res_sr};

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Sum      <= '0;
      Cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= A;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next[WIDTH-1:1];
          carry  <= fa_co;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB on this last bit
            Sum      <= res_next;
            Cout     <= fa_co;
            overflow <= carry ^ fa_co;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against a cycle-timeline arithmetic model.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, Cout, overflow;
  logic [W-1:0] Sum;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .Sum      (Sum),
    .Cout     (Cout),
    .overflow (overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {overflow, carry-out, sum} of a +/- b from plain arithmetic
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c, input logic s);
    logic [W-1:0] bv;
    logic         ci;
    logic [W:0]   t;
    logic         ov;
    bv = s ? ~b : b;
    ci = s ? 1'b1 : c;
    t  = {1'b0, a} + {1'b0, bv} + {{W{1'b0}}, ci};
    ov = (a[W-1] == bv[W-1]) && (t[W-1] != a[W-1]);
    return {ov, t};
  endfunction

  // Model: an accepted start at edge c publishes its result at edge c+W.
  int           cyc = 0;
  int           m_end = 0;
  logic         m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic [W+1:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      cyc    <= cyc + 1;
      m_done <= 1'b0;
      if (m_busy && cyc == m_end) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        {m_ovf, m_cout, m_sum} <= m_pend;
      end
      if (!m_busy && start) begin
        m_busy <= 1'b1;
        m_end  <= cyc + W;
        m_pend <= ref_op(A, B, Cin, sub);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("sum", Sum, m_sum);
      chk("cout", Cout, m_cout);
      chk("overflow", overflow, m_ovf);
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, input bit chain, input bit repulse,
                        output int lat, output int nbusy);
    if (!chain) @(negedge clk);
    A = a; B = b; Cin = c; sub = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    lat = 0;
    nbusy = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (repulse && (lat == 3 || lat == 5)) begin
        A = W'($urandom); B = W'($urandom); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    if (!done) chk("done_timeout", done, 1'b1);
  endtask

  int lat, nb;

  initial begin
    #1 rst_n = 1'b0;
    #2 cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (6) @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_sum", Sum, 8'h00);

    run_op(8'h3C, 8'h15, 1'b1, 1'b0, 1'b0, 1'b0, lat, nb);
    chk("lat_3c15", lat, 9);
    chk("busy_cycles", nb, 8);
    chk("sum_3c15", Sum, 8'h52);
    chk("cout_3c15", Cout, 1'b0);
    chk("ovf_3c15", overflow, 1'b0);

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, lat, nb);
    chk("sum_ff01", Sum, 8'h00);
    chk("cout_ff01", Cout, 1'b1);
    chk("ovf_ff01", overflow, 1'b0);

    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, lat, nb);
    chk("sum_7f01", Sum, 8'h80);
    chk("cout_7f01", Cout, 1'b0);
    chk("ovf_7f01", overflow, 1'b1);

    run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, lat, nb);
    chk("lat_repulse", lat, 9);
    chk("sum_repulse", Sum, 8'h46);

    run_op(8'h20, 8'h30, 1'b1, 1'b0, 1'b1, 1'b0, lat, nb);
    chk("lat_chain", lat, 9);
    chk("sum_chain", Sum, 8'h51);

    @(negedge clk);
    A = 8'hAA; B = 8'h55; Cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_sum", Sum, 8'h00);
    chk("abort_done", done, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, lat, nb);
    chk("lat_after_rst", lat, 9);
    chk("sum_after_rst", Sum, 8'h02);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, lat, nb);
    chk("sum_sub_0507", Sum, 8'hFE);
    chk("cout_sub_0507", Cout, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, lat, nb);
    chk("sum_sub_8001", Sum, 8'h7F);
    chk("ovf_sub_8001", overflow, 1'b1);
`endif

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      A = W'($urandom);
      B = W'($urandom);
      Cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'($urandom);
`endif
      if (i == 700) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
